vend_credit_ctrl: RTL and testbench

//   Parametrised credit/vend/change controller for the vending machine top level.
//   - Accepts debounced single-cycle coin pulses and keeps the credit register.
//   - Holds one editable price per product channel (NUM_CH channels).
//   - Arbitrates buy requests and drives one dispense-servo position bit per channel.
//   - Runs a coin-by-coin change-return loop.
//   - Sits between the input debouncers and the servo controllers and 7-seg display mux.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_credit_ctrl_if.sv | 31 +++
 rtl/vend_hold_timer.sv | 29 ++
 rtl/vend_credit_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vend_credit_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the vending credit controller: FSM state codes and coin values.
package vend_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_VEND    = 2'd1;
  localparam logic [1:0] S_CHG_ON  = 2'd2;
  localparam logic [1:0] S_CHG_OFF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_VEND    = S_VEND,
    ST_CHG_ON  = S_CHG_ON,
    ST_CHG_OFF = S_CHG_OFF
  } vend_state_e;

  localparam int NICKEL_VAL  = 5;
  localparam int DIME_VAL    = 10;
  localparam int QUARTER_VAL = 25;

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Coin/buy/price/change inputs and credit/servo/status outputs of the credit controller.
interface vend_credit_ctrl_if #(
  parameter int NUM_CH   = 2,
  parameter int CREDIT_W = 16,
  parameter int PRICE_W  = 16
);
  logic                      coin_nickel;
  logic                      coin_dime;
  logic                      coin_quarter;
  logic [NUM_CH-1:0]         buy_req;
  logic [NUM_CH-1:0]         price_inc;
  logic [NUM_CH-1:0]         price_dec;
  logic                      change_req;
  logic [CREDIT_W-1:0]       credit;
  logic [NUM_CH*PRICE_W-1:0] prices;
  logic [NUM_CH-1:0]         vend_pos;
  logic                      change_pos;
  logic                      insufficient;
  logic                      coin_reject;
  logic                      busy;

  modport master (
    output coin_nickel, coin_dime, coin_quarter, buy_req, price_inc, price_dec, change_req,
    input  credit, prices, vend_pos, change_pos, insufficient, coin_reject, busy
  );

  modport slave (
    input  coin_nickel, coin_dime, coin_quarter, buy_req, price_inc, price_dec, change_req,
    output credit, prices, vend_pos, change_pos, insufficient, coin_reject, busy
  );
endinterface

// File: rtl/vend_hold_timer.sv
// Servo hold timer: loads HOLD_CYC-1 on start, counts down, done is high at terminal count.
module vend_hold_timer #(
  parameter int HOLD_CYC = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);
  localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [TW-1:0] count;
  logic          active;

  assign done = active && (count == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      count  <= TW'(HOLD_CYC - 1);
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) active <= 1'b0;
      else             count  <= count - TW'(1);
    end
  end
endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit / vend / change controller. Define VEND_PRICE_EDIT_EN to make channel prices
// editable registers; otherwise every price is the constant PRICE_INIT.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CREDIT_W    = 16,
  parameter int PRICE_W     = 16,
  parameter int PRICE_INIT  = 100,
  parameter int PRICE_STEP  = 5,
  parameter int PRICE_MAX   = 995,
  parameter int CREDIT_MAX  = 995,
  parameter int CHANGE_UNIT = 5,
  parameter int HOLD_CYC    = 50_000_000
) (
  input logic               clock,
  input logic               reset,
  vend_credit_ctrl_if.slave bus
);
  localparam int AW = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 2;
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  vend_state_e         state;
  logic [CREDIT_W-1:0] credit_q;
  logic [NUM_CH-1:0]   vend_pos_q;
  logic                change_pos_q, insufficient_q, coin_reject_q, busy_q;
  logic [PRICE_W-1:0]  price_q [NUM_CH];

  logic [AW-1:0]       coin_sum, credit_x, credit_add;
  logic                coin_any, coin_ok;
  logic [SW-1:0]       sel;
  logic                buy_any, vend_go, chg_go, rechg, tmr_start, tmr_done;
  logic [PRICE_W-1:0]  win_price;

  function automatic logic [PRICE_W-1:0] price_inc_sat(input logic [PRICE_W-1:0] p);
    logic [AW-1:0] s;
    s = AW'(p) + AW'(PRICE_STEP);
    return (s > AW'(PRICE_MAX)) ? PRICE_W'(PRICE_MAX) : PRICE_W'(s);
  endfunction

  function automatic logic [AW-1:0] change_amt(input logic [AW-1:0] c);
    return (c < AW'(CHANGE_UNIT)) ? c : AW'(CHANGE_UNIT);
  endfunction

  // Coins are judged as one sum: either the whole sum fits under the cap or all of it is dropped.
  assign coin_sum = (bus.coin_nickel  ? AW'(NICKEL_VAL)  : AW'(0))
                  + (bus.coin_dime    ? AW'(DIME_VAL)    : AW'(0))
                  + (bus.coin_quarter ? AW'(QUARTER_VAL) : AW'(0));
  assign coin_any   = bus.coin_nickel | bus.coin_dime | bus.coin_quarter;
  assign credit_x   = AW'(credit_q);
  assign coin_ok    = coin_any && ((credit_x + coin_sum) <= AW'(CREDIT_MAX));
  assign credit_add = coin_ok ? coin_sum : AW'(0);

  always_comb begin
    sel     = '0;
    buy_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.buy_req[i]) begin
        sel     = SW'(i);
        buy_any = 1'b1;
      end
    end
  end

  // Every decision below looks at the registered credit, never at this cycle's coin.
  assign win_price = price_q[sel];
  assign vend_go   = (state == ST_IDLE) && buy_any && (credit_x >= AW'(win_price));
  assign chg_go    = (state == ST_IDLE) && !buy_any && bus.change_req && (credit_q != '0);
  assign rechg     = (state == ST_CHG_OFF) && tmr_done && (credit_q != '0);
  assign tmr_start = vend_go || chg_go || rechg || ((state == ST_CHG_ON) && tmr_done);

  vend_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_timer (
    .clock (clock),
    .reset (reset),
    .start (tmr_start),
    .done  (tmr_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      credit_q       <= '0;
      vend_pos_q     <= '0;
      change_pos_q   <= 1'b0;
      insufficient_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      coin_reject_q <= coin_any && !coin_ok;
      credit_q      <= CREDIT_W'(credit_x + credit_add);
      if (coin_ok) insufficient_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vend_go) begin
            credit_q       <= CREDIT_W'(credit_x + credit_add - AW'(win_price));
            vend_pos_q     <= NUM_CH'(1) << sel;
            insufficient_q <= 1'b0;
            state          <= ST_VEND;
            busy_q         <= 1'b1;
          end else if (buy_any) begin
            insufficient_q <= 1'b1;
          end else if (chg_go) begin
            change_pos_q <= 1'b1;
            state        <= ST_CHG_ON;
            busy_q       <= 1'b1;
          end
        end
        ST_VEND: begin
          if (tmr_done) begin
            vend_pos_q <= '0;
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
          end
        end
        ST_CHG_ON: begin
          if (tmr_done) begin
            change_pos_q <= 1'b0;
            credit_q     <= CREDIT_W'(credit_x + credit_add - change_amt(credit_x));
            state        <= ST_CHG_OFF;
          end
        end
        ST_CHG_OFF: begin
          if (rechg) begin
            change_pos_q <= 1'b1;
            state        <= ST_CHG_ON;
          end else if (tmr_done) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VEND_PRICE_EDIT_EN
  // Edits land on the same edge as a buy, so the buy compares against the old price.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) price_q[i] <= PRICE_W'(PRICE_INIT);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.price_inc[i] && !bus.price_dec[i])
          price_q[i] <= price_inc_sat(price_q[i]);
        else if (bus.price_dec[i] && !bus.price_inc[i] && (price_q[i] >= PRICE_W'(PRICE_STEP)))
          price_q[i] <= price_q[i] - PRICE_W'(PRICE_STEP);
      end
    end
  end
`else
  logic unused_price_edit;
  assign unused_price_edit = ^{bus.price_inc, bus.price_dec};
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) price_q[i] = PRICE_W'(PRICE_INIT);
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_price_bus
    assign bus.prices[g*PRICE_W +: PRICE_W] = price_q[g];
  end

  assign bus.credit       = credit_q;
  assign bus.vend_pos     = vend_pos_q;
  assign bus.change_pos   = change_pos_q;
  assign bus.insufficient = insufficient_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: directed scenarios then random traffic, checked
// every cycle against a behavioural model of the credit/vend/change rules.
module tb_vend_credit_ctrl;
  localparam int NUM_CH = 2, CREDIT_W = 16, PRICE_W = 16, HOLD = 8;
  localparam int P_INIT = 100, P_STEP = 5, P_MAX = 995, C_MAX = 995, UNIT = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  vend_credit_ctrl_if #(.NUM_CH(NUM_CH), .CREDIT_W(CREDIT_W), .PRICE_W(PRICE_W)) bus ();

  vend_credit_ctrl #(
    .NUM_CH(NUM_CH), .CREDIT_W(CREDIT_W), .PRICE_W(PRICE_W), .PRICE_INIT(P_INIT),
    .PRICE_STEP(P_STEP), .PRICE_MAX(P_MAX), .CREDIT_MAX(C_MAX), .CHANGE_UNIT(UNIT),
    .HOLD_CYC(HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [CREDIT_W-1:0]       credit;
    logic [NUM_CH*PRICE_W-1:0] prices;
    logic [NUM_CH-1:0]         vend_pos;
    logic                      change_pos;
    logic                      insufficient;
    logic                      coin_reject;
    logic                      busy;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: mode 0 idle, 1 dispensing, 2 coin out, 3 gap between coins.
  int m_credit, m_mode, m_rem, m_vch;
  int m_price [NUM_CH];
  bit m_ins, m_rej;

  function automatic void model_reset();
    m_credit = 0; m_mode = 0; m_rem = 0; m_vch = 0; m_ins = 0; m_rej = 0;
    for (int i = 0; i < NUM_CH; i++) m_price[i] = P_INIT;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int   c;
    o = '0;
    c = m_credit;
    o.credit = c[CREDIT_W-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      c = m_price[i];
      o.prices[i*PRICE_W +: PRICE_W] = c[PRICE_W-1:0];
    end
    o.vend_pos     = (m_mode == 1) ? NUM_CH'(1) << m_vch : '0;
    o.change_pos   = (m_mode == 2);
    o.insufficient = m_ins;
    o.coin_reject  = m_rej;
    o.busy         = (m_mode != 0);
    return o;
  endfunction

  function automatic void model_step(bit n, bit d, bit q, bit [1:0] buy, bit [1:0] inc,
                                     bit [1:0] dec, bit chg);
    int sum, nc, w;
    bit ok;
    sum   = (n ? 5 : 0) + (d ? 10 : 0) + (q ? 25 : 0);
    ok    = (sum > 0) && (m_credit + sum <= C_MAX);
    m_rej = (sum > 0) && !ok;
    nc    = m_credit + (ok ? sum : 0);
    if (ok) m_ins = 0;
    if (m_mode == 0) begin
      w = -1;
      for (int i = 0; i < NUM_CH; i++) if (buy[i] && w < 0) w = i;
      if (w >= 0) begin
        if (m_credit >= m_price[w]) begin
          nc = nc - m_price[w]; m_vch = w; m_ins = 0; m_mode = 1; m_rem = HOLD;
        end else begin
          m_ins = 1;
        end
      end else if (chg && m_credit > 0) begin
        m_mode = 2; m_rem = HOLD;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_mode == 1) begin
          m_mode = 0;
        end else if (m_mode == 2) begin
          nc = nc - ((m_credit < UNIT) ? m_credit : UNIT);
          m_mode = 3; m_rem = HOLD;
        end else if (m_credit > 0) begin
          m_mode = 2; m_rem = HOLD;
        end else begin
          m_mode = 0;
        end
      end
    end
`ifdef VEND_PRICE_EDIT_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (inc[i] && !dec[i])                        m_price[i] = (m_price[i] + P_STEP > P_MAX) ? P_MAX : m_price[i] + P_STEP;
      else if (dec[i] && !inc[i] && m_price[i] >= P_STEP) m_price[i] = m_price[i] - P_STEP;
    end
`else
    if (inc != dec) w = 0;
`endif
    m_credit = nc;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.credit       = bus.credit;
    o.prices       = bus.prices;
    o.vend_pos     = bus.vend_pos;
    o.change_pos   = bus.change_pos;
    o.insufficient = bus.insufficient;
    o.coin_reject  = bus.coin_reject;
    o.busy         = bus.busy;
    return o;
  endfunction

  function automatic void check(string name, obs_t got, obs_t want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got credit=%0d prices=%h vend=%b chg=%b ins=%b rej=%b busy=%b, want credit=%0d prices=%h vend=%b chg=%b ins=%b rej=%b busy=%b",
               name, $time, got.credit, got.prices, got.vend_pos, got.change_pos, got.insufficient,
               got.coin_reject, got.busy, want.credit, want.prices, want.vend_pos, want.change_pos,
               want.insufficient, want.coin_reject, want.busy);
    end
  endfunction

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", sample(), e);
      end
    end
  end

  task automatic drive(bit n, bit d, bit q, bit [1:0] buy, bit [1:0] inc, bit [1:0] dec, bit chg);
    bus.coin_nickel = n; bus.coin_dime = d; bus.coin_quarter = q;
    bus.buy_req = buy; bus.price_inc = inc; bus.price_dec = dec; bus.change_req = chg;
  endtask

  // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
  task automatic step(bit n, bit d, bit q, bit [1:0] buy, bit [1:0] inc, bit [1:0] dec, bit chg);
    drive(n, d, q, buy, inc, dec, chg);
    model_step(n, d, q, buy, inc, dec, chg);
    exp_q.push_back(model_out());
    @(negedge clock);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
  endtask

  task automatic quarter(); step(0, 0, 1, 2'b00, 2'b00, 2'b00, 0); endtask
  task automatic dime();    step(0, 1, 0, 2'b00, 2'b00, 2'b00, 0); endtask
  task automatic nickel();  step(1, 0, 0, 2'b00, 2'b00, 2'b00, 0); endtask

  // Asserts reset between clock edges and checks that outputs clear without waiting for an edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    #1;
    model_reset();
    check("async_reset", sample(), model_out());
    repeat (2) begin
      exp_q.push_back(model_out());
      @(negedge clock);
    end
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit n, d, q, chg;
    bit [1:0] buy, inc, dec;
    drive(0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    model_reset();
    @(negedge clock);
    do_reset();

    repeat (4) quarter();
    step(0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    idle(12);

    repeat (4) quarter();
    step(0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    idle(3);
    do_reset();

    repeat (3) quarter();
    dime();
    nickel();
    step(0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
    idle(2);
    nickel();
    step(0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    idle(19 * 2 * HOLD + 4);

    dime();
    nickel();
    step(0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    idle(3 * 2 * HOLD + 4);

    dime();
    nickel();
    step(0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    idle(HOLD + 3);
    dime();
    idle(5 * 2 * HOLD + 4);

    repeat (39) quarter();
    dime();
    nickel();
    quarter();
    nickel();
    nickel();
    step(0, 0, 1, 2'b01, 2'b00, 2'b00, 0);
    idle(HOLD + 2);

    do_reset();
    repeat (4) quarter();
    step(0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    idle(HOLD + 2);

`ifdef VEND_PRICE_EDIT_EN
    step(0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
    step(0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
    repeat (21) step(0, 0, 0, 2'b00, 2'b00, 2'b01, 0);
    step(0, 0, 0, 2'b00, 2'b11, 2'b11, 0);
    repeat (4) quarter();
    step(0, 0, 0, 2'b01, 2'b01, 2'b00, 0);
    idle(HOLD + 2);
    do_reset();
`endif

    for (int i = 0; i < 3000; i++) begin
      n   = ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 6) == 0);
      q   = ($urandom_range(0, 4) == 0);
      buy = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      chg = ($urandom_range(0, 11) == 0);
      inc = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      dec = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(n, d, q, buy, inc, dec, chg);
      if (i == 1500) do_reset();
    end
    idle(2);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
